// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and memory-wait freezes,
// with a watchdog pulse for slow loads and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_adr1,
    input  logic [4:0]       id_adr2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_wa,
    input  logic             ex_mem_read,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             stall_fe,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             freeze_all,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    localparam logic [7:0]       WAIT_MAX  = 8'hFF;
    localparam logic [7:0]       TO_PRE    = 8'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             load_in_mem_q, load_in_mem_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic rs1_hit;
    logic rs2_hit;
    logic load_use;

    // Hazard detection and the priority resolution: freeze > branch > load-use.
    assign rs1_hit  = id_rs1_used && (id_adr1 == ex_wa);
    assign rs2_hit  = id_rs2_used && (id_adr2 == ex_wa);
    assign load_use = ex_mem_read && (ex_wa != 5'd0) && (rs1_hit || rs2_hit);

    assign freeze_all = load_in_mem_q && !mem_ready;
    assign stall_fe   = freeze_all || (!branch_taken && load_use);
    assign bubble_ex  = !freeze_all && (branch_taken || load_use);
    assign flush_id   = !freeze_all && branch_taken;

    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_cycles_q;

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case leaves a latch.
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        mem_timeout_d  = 1'b0;
        load_in_mem_d  = freeze_all ? load_in_mem_q : ex_mem_read;
        stall_cycles_d = stall_cycles_q;

        if (stall_fe && (stall_cycles_q != STALL_MAX)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end

        case (state_q)
            RUN: begin
                if (freeze_all) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (freeze_all) begin
                    if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                    // Saturation at 255 keeps this to one pulse per episode.
                    mem_timeout_d = (wait_cnt_q == TO_PRE);
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            wait_cnt_q     <= 8'd0;
            load_in_mem_q  <= 1'b0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            load_in_mem_q  <= load_in_mem_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the number of MEM_WAIT cycles before mem_timeout pulses (range 2..255).
REQ-002 SHALL have parameter CNT_W, default 16, the width of stall_cycles.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; ports are named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 id_adr1 / id_adr2  input  5 each  rs1/rs2 source register addresses of the instruction in ID.
REQ-007 id_rs1_used / id_rs2_used  input  1 each  the ID instruction actually reads rs1/rs2.
REQ-008 ex_wa  input  5  destination register of the instruction in EX.
REQ-009 ex_mem_read  input  1  the EX instruction is a load.
REQ-010 branch_taken  input  1  a branch or jump in EX redirects the PC this cycle.
REQ-011 mem_ready  input  1  data memory completes the MEM-stage load this cycle.
REQ-012 stall_fe  output  1  hold the PC and the IF/ID register.
REQ-013 bubble_ex  output  1  load a NOP into the ID/EX register.
REQ-014 flush_id  output  1  load a NOP into the IF/ID register.
REQ-015 freeze_all  output  1  hold PC, IF/ID, ID/EX and EX/MEM; insert a bubble into MEM/WB.
REQ-016 mem_timeout  output  1  single-cycle error pulse.
REQ-017 stall_cycles  output  CNT_W  saturating count of stalled cycles.

Function
REQ-018 load_use SHALL equal ex_mem_read & (ex_wa!=0) & ((id_rs1_used & id_adr1==ex_wa) | (id_rs2_used & id_adr2==ex_wa)).
REQ-019 load_in_mem SHALL be a register.
  - When freeze_all=0: loads ex_mem_read & ~bubble_ex-independent value ex_mem_read on each rising edge.
  - When freeze_all=1: holds its value.
REQ-020 freeze_all SHALL equal load_in_mem & ~mem_ready, combinationally, with zero latency.
REQ-021 Priority order SHALL be: freeze_all, then branch_taken, then load_use.
REQ-022 While freeze_all=1: stall_fe=1, bubble_ex=0, flush_id=0.
  - branch_taken and load_use are ignored that cycle.
  - Upstream holds the EX instruction, so both are re-evaluated once freeze_all drops.
REQ-023 With freeze_all=0 and branch_taken=1: flush_id=1, bubble_ex=1, stall_fe=0, regardless of load_use.
REQ-024 With freeze_all=0, branch_taken=0 and load_use=1: stall_fe=1, bubble_ex=1, flush_id=0, for exactly one cycle per load-use pair.
REQ-025 With no condition active, all of stall_fe, bubble_ex, flush_id and freeze_all SHALL be 0.
REQ-026 The FSM SHALL have states RUN and MEM_WAIT, plus an 8-bit wait_cnt.
REQ-027 RUN -> MEM_WAIT SHALL occur on a rising edge with freeze_all=1; wait_cnt is set to 1.
REQ-028 In MEM_WAIT with freeze_all=1, wait_cnt SHALL increment and saturate at 255.
REQ-029 MEM_WAIT -> RUN SHALL occur on the rising edge where mem_ready=1; wait_cnt is cleared to 0.
REQ-030 mem_timeout SHALL be registered and pulse high for exactly one cycle, on the edge where wait_cnt transitions TIMEOUT-1 -> TIMEOUT.
  - It pulses at most once per MEM_WAIT episode.
  - The freeze continues until mem_ready.
REQ-031 stall_cycles SHALL increment on each rising edge where stall_fe=1 (which includes freeze cycles) and saturate at 2^CNT_W-1 without wrap.
REQ-032 Back-to-back loads (MEM load and EX load both present) SHALL be handled as follows:
  - The EX load moves into MEM only after the MEM load receives mem_ready.
  - load_in_mem then stays 1 with no idle cycle.
REQ-033 mem_ready=1 while load_in_mem=0 SHALL be ignored.
REQ-034 ex_wa=0 SHALL never produce a load-use stall, even when ID reads x0.

Reset
REQ-035 While rst_n=0, the following SHALL hold asynchronously:
  - load_in_mem=0, state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0.
  - Hence freeze_all=0, and stall_fe, bubble_ex and flush_id follow only branch_taken and load_use.
REQ-036 Reset asserted during MEM_WAIT SHALL abort the wait immediately, with no mem_timeout pulse.
  - The first edge after rst_n rises SHALL behave as from RUN.

Verification
REQ-037 Load-use: ex_mem_read=1, ex_wa=5, id_adr1=5, id_rs1_used=1, branch_taken=0 -> stall_fe=1, bubble_ex=1 for 1 cycle; stall_cycles 0->1.
REQ-038 Branch over load-use: same as REQ-037 plus branch_taken=1 -> flush_id=1, bubble_ex=1, stall_fe=0.
REQ-039 Memory wait: load in MEM, mem_ready held 0 for 3 cycles then 1 -> freeze_all=1 for 3 cycles, state MEM_WAIT, wait_cnt reaches 3, return to RUN; stall_cycles +3.
REQ-040 Timeout: TIMEOUT=4, mem_ready held 0 for 10 cycles -> exactly one mem_timeout pulse, 4 cycles after freeze start; freeze_all stays 1 until mem_ready.
REQ-041 Reset mid-wait: rst_n=0 during MEM_WAIT -> freeze_all=0 immediately, stall_cycles=0, no mem_timeout after release.
REQ-042 x0 and unused operands: ex_wa=0 with matching id_adr1, or id_rs2_used=0 with matching id_adr2 -> no stall.
